// File: rtl/inj_seq_pkg.sv
// Shared widths, config payload type and helpers for the injection sequencer.
package inj_seq_pkg;

    localparam int unsigned INJ_NCH     = 4;
    localparam int unsigned INJ_PHASE_W = 16;
    localparam int unsigned INJ_CYC_W   = 32;

    // One channel's schedule: start phase, firing revolution, pulse width.
    typedef struct packed {
        logic [INJ_PHASE_W-1:0] phase;
        logic                   rev;
        logic [INJ_CYC_W-1:0]   on;
    } inj_cfg_t;

    localparam inj_cfg_t INJ_CFG_RESET = '{phase: '0, rev: 1'b0, on: '0};

    // Build a config entry from its individual fields.
    function automatic inj_cfg_t inj_cfg_pack(
        input logic [INJ_PHASE_W-1:0] phase,
        input logic                   rev,
        input logic [INJ_CYC_W-1:0]   on
    );
        inj_cfg_t c;
        c.phase = phase;
        c.rev   = rev;
        c.on    = on;
        return c;
    endfunction

    // A zero pulse width marks a channel as disabled.
    function automatic logic inj_cfg_enabled(input inj_cfg_t c);
        return (c.on != '0);
    endfunction

endpackage

// File: rtl/inj_pulse_timer.sv
// Per-channel pulse timer: loads a width when idle, counts down to zero.
module inj_pulse_timer
    import inj_seq_pkg::*;
#(
    parameter int unsigned CYC_W = INJ_CYC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CYC_W-1:0] load_val,
    output logic             busy
);

    logic [CYC_W-1:0] timer_q;
    logic [CYC_W-1:0] timer_d;

    // Next count: load only from idle, otherwise decrement while nonzero.
    always_comb begin
        timer_d = timer_q;
        if (timer_q == '0) begin
            if (load) begin
                timer_d = load_val;
            end
        end else begin
            timer_d = timer_q - CYC_W'(1);
        end
    end

    // Count register; reset drops any pulse in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign busy = (timer_q != '0);

endmodule

// File: rtl/inj_sequencer.sv
// Multi-channel sequential injection scheduler: revolution tracking from crank
// sync, shadow/active config tables, phase match and per-channel pulse timers.
module inj_sequencer
    import inj_seq_pkg::*;
#(
    parameter  int unsigned NCH     = INJ_NCH,
    parameter  int unsigned PHASE_W = INJ_PHASE_W,
    parameter  int unsigned CYC_W   = INJ_CYC_W,
    localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               trigger,
    input  logic [PHASE_W-1:0] eng_phase,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic               cfg_rev,
    input  logic [CYC_W-1:0]   cfg_on,
    output logic               synced,
    output logic [NCH-1:0]     inj_out,
    output logic [NCH-1:0]     overlap_err
);

    // Engine-cycle tracking
    logic rev_q;
    logic rev_d;
    logic synced_q;
    logic synced_d;
    logic cfg_ready_q;

    // Config tables: shadow takes writes, active is used for matching
    inj_cfg_t shadow_q [NCH];
    inj_cfg_t shadow_d [NCH];
    inj_cfg_t active_q [NCH];
    inj_cfg_t active_d [NCH];
    inj_cfg_t sel_c    [NCH];

    logic [NCH-1:0] fire_c;
    logic [NCH-1:0] busy_c;
    logic [NCH-1:0] overlap_q;
    logic [NCH-1:0] overlap_d;

    logic sync_c;
    logic rev_n_c;
    logic synced_n_c;
    logic commit_c;
    logic accept_c;

    // Sync, revolution and commit decode for the current cycle.
    always_comb begin
        sync_c     = trigger && (eng_phase == '0);
        rev_n_c    = sync_c ? ~rev_q : rev_q;
        synced_n_c = synced_q | sync_c;
        commit_c   = sync_c && !rev_n_c;
        accept_c   = cfg_valid && cfg_ready_q;
        rev_d      = rev_n_c;
        synced_d   = synced_n_c;
    end

    // Shadow writes and atomic commit; commit copies the pre-write shadow.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = commit_c ? shadow_q[i] : active_q[i];
            if (accept_c && (cfg_ch == CH_W'(i))) begin
                shadow_d[i] = inj_cfg_pack(INJ_PHASE_W'(cfg_phase), cfg_rev,
                                           INJ_CYC_W'(cfg_on));
            end
        end
    end

    // Phase/revolution match; on a commit cycle the new (shadow) config is used.
    always_comb begin
        fire_c    = '0;
        overlap_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            sel_c[i]  = commit_c ? shadow_q[i] : active_q[i];
            fire_c[i] = synced_n_c && trigger
                        && (eng_phase == PHASE_W'(sel_c[i].phase))
                        && (rev_n_c == sel_c[i].rev)
                        && inj_cfg_enabled(sel_c[i]);
            overlap_d[i] = fire_c[i] && busy_c[i];
        end
    end

    // Control and table registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rev_q       <= 1'b1;
            synced_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            overlap_q   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow_q[i] <= INJ_CFG_RESET;
                active_q[i] <= INJ_CFG_RESET;
            end
        end else begin
            rev_q       <= rev_d;
            synced_q    <= synced_d;
            cfg_ready_q <= 1'b1;
            overlap_q   <= overlap_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // One pulse timer per channel; a fire while busy is dropped here.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        inj_pulse_timer #(
            .CYC_W (CYC_W)
        ) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (fire_c[g] && !busy_c[g]),
            .load_val (CYC_W'(sel_c[g].on)),
            .busy     (busy_c[g])
        );
    end

    // en truncates the visible pulse without pausing the timers.
    assign inj_out     = busy_c & {NCH{en}};
    assign overlap_err = overlap_q;
    assign synced      = synced_q;
    assign cfg_ready   = cfg_ready_q;

endmodule

// File: tb/tb_inj_sequencer.sv
// Directed bench for inj_sequencer with immediate-assertion checks.
module tb_inj_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        trigger;
    logic [15:0] eng_phase;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_phase;
    logic        cfg_rev;
    logic [31:0] cfg_on;
    logic        synced;
    logic [3:0]  inj_out;
    logic [3:0]  overlap_err;

    int n_checks = 0;
    int n_errors = 0;

    inj_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .trigger     (trigger),
        .eng_phase   (eng_phase),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_phase   (cfg_phase),
        .cfg_rev     (cfg_rev),
        .cfg_on      (cfg_on),
        .synced      (synced),
        .inj_out     (inj_out),
        .overlap_err (overlap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle with a crank tooth at the given phase.
    task automatic trig(input logic [15:0] ph);
        trigger   = 1'b1;
        eng_phase = ph;
        tick();
        trigger   = 1'b0;
        eng_phase = 16'd0;
    endtask

    // One-cycle config write.
    task automatic cfg(input logic [1:0] ch, input logic [15:0] ph, input logic rv,
                       input logic [31:0] on);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_phase = ph;
        cfg_rev   = rv;
        cfg_on    = on;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        trigger   = 1'b0;
        eng_phase = 16'd0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_phase = 16'd0;
        cfg_rev   = 1'b0;
        cfg_on    = 32'd0;

        // Reset state
        tick();
        tick();
        check("rst_inj", 32'(inj_out), 32'h0);
        check("rst_ovl", 32'(overlap_err), 32'h0);
        check("rst_synced", 32'(synced), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(cfg_ready), 32'h1);
        check("synced_pre_sync", 32'(synced), 32'h0);

        // 1: sync tracking, no output before config
        trig(16'd0);
        check("synced_first_s", 32'(synced), 32'h1);
        check("no_inj_s1", 32'(inj_out), 32'h0);
        trig(16'd0);
        check("no_inj_s2", 32'(inj_out), 32'h0);

        // 2: ch0 phase 100 rev 0 width 50
        cfg(2'd0, 16'd100, 1'b0, 32'd50);
        trig(16'd0);
        trig(16'd100);
        for (int k = 0; k < 50; k++) begin
            check("ch0_pulse_high", 32'(inj_out), 32'h1);
            tick();
        end
        check("ch0_pulse_end", 32'(inj_out), 32'h0);
        trig(16'd0);
        trig(16'd100);
        check("ch0_rev1_nofire", 32'(inj_out), 32'h0);
        check("ch0_rev1_noovl", 32'(overlap_err), 32'h0);

        // 3: mid-cycle write waits for commit
        cfg(2'd1, 16'd200, 1'b1, 32'd20);
        trig(16'd200);
        check("ch1_before_commit", 32'(inj_out), 32'h0);
        trig(16'd0);
        trig(16'd200);
        check("ch1_wrong_rev", 32'(inj_out), 32'h0);
        trig(16'd0);
        trig(16'd200);
        check("ch1_fire_first", 32'(inj_out), 32'h2);
        repeat (19) tick();
        check("ch1_fire_last", 32'(inj_out), 32'h2);
        tick();
        check("ch1_fire_end", 32'(inj_out), 32'h0);
        // write coincident with commit applies one engine cycle later
        trigger   = 1'b1;
        eng_phase = 16'd0;
        cfg(2'd1, 16'd300, 1'b0, 32'd7);
        trigger   = 1'b0;
        trig(16'd300);
        check("ch1_coincident_old", 32'(inj_out), 32'h0);
        trig(16'd0);
        trig(16'd300);
        check("ch1_coincident_rev1", 32'(inj_out), 32'h0);
        trig(16'd0);
        trig(16'd300);
        check("ch1_new_first", 32'(inj_out), 32'h2);
        repeat (6) tick();
        check("ch1_new_last", 32'(inj_out), 32'h2);
        tick();
        check("ch1_new_end", 32'(inj_out), 32'h0);

        // 4: re-fire while on -> overlap, no extend
        cfg(2'd2, 16'd400, 1'b0, 32'd1000);
        trig(16'd0);
        trig(16'd0);
        trig(16'd400);
        check("ch2_fire", 32'(inj_out), 32'h4);
        check("ch2_no_ovl", 32'(overlap_err), 32'h0);
        repeat (9) tick();
        trig(16'd400);
        check("ch2_ovl_pulse", 32'(overlap_err), 32'h4);
        check("ch2_still_on", 32'(inj_out), 32'h4);
        tick();
        check("ch2_ovl_clear", 32'(overlap_err), 32'h0);
        repeat (988) tick();
        check("ch2_last_cycle", 32'(inj_out), 32'h4);
        tick();
        check("ch2_end_1000", 32'(inj_out), 32'h0);

        // 5: en truncates, timer keeps its schedule
        trig(16'd100);
        repeat (4) tick();
        check("en_pulse_on", 32'(inj_out), 32'h1);
        en = 1'b0;
        #1;
        check("en_low_gate", 32'(inj_out), 32'h0);
        repeat (25) tick();
        check("en_low_hold", 32'(inj_out), 32'h0);
        en = 1'b1;
        #1;
        check("en_restore", 32'(inj_out), 32'h1);
        repeat (20) tick();
        check("en_last_cycle", 32'(inj_out), 32'h1);
        tick();
        check("en_orig_end", 32'(inj_out), 32'h0);
        // reset mid-pulse
        trig(16'd0);
        trig(16'd0);
        trig(16'd100);
        check("pre_rst_pulse", 32'(inj_out), 32'h1);
        rst_n = 1'b0;
        tick();
        check("midrst_inj", 32'(inj_out), 32'h0);
        check("midrst_synced", 32'(synced), 32'h0);
        check("midrst_ready", 32'(cfg_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        check("midrst_ready_back", 32'(cfg_ready), 32'h1);
        check("midrst_still_unsynced", 32'(synced), 32'h0);

        // 6: four channels at the same phase fire together
        cfg(2'd0, 16'd500, 1'b0, 32'd3);
        cfg(2'd1, 16'd500, 1'b0, 32'd4);
        cfg(2'd2, 16'd500, 1'b0, 32'd5);
        cfg(2'd3, 16'd500, 1'b0, 32'd6);
        trig(16'd0);
        check("all_synced", 32'(synced), 32'h1);
        trig(16'd500);
        check("all_c1", 32'(inj_out), 32'hF);
        tick();
        check("all_c2", 32'(inj_out), 32'hF);
        tick();
        check("all_c3", 32'(inj_out), 32'hF);
        tick();
        check("all_c4", 32'(inj_out), 32'hE);
        tick();
        check("all_c5", 32'(inj_out), 32'hC);
        tick();
        check("all_c6", 32'(inj_out), 32'h8);
        tick();
        check("all_end", 32'(inj_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
